// File: rtl/dfb_pkg.sv
// rtl/dfb_pkg.sv - shared types, default palette and cell addressing for the dual frame buffer
package dfb_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT_VB
  } dfb_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // black, the seven tetromino colours, a grey ramp, white
  localparam rgb_t DEFAULT_PALETTE [16] = '{
    24'h000000, 24'h00FFFF, 24'h0000FF, 24'hFF8000,
    24'hFFFF00, 24'h00FF00, 24'h800080, 24'hFF0000,
    24'h202020, 24'h404040, 24'h606060, 24'h808080,
    24'hA0A0A0, 24'hC0C0C0, 24'hE0E0E0, 24'hFFFFFF
  };

  function automatic int unsigned cell_addr(input int unsigned cx, input int unsigned cy,
                                            input int unsigned w);
    return cy * w + cx;
  endfunction

endpackage

// File: rtl/dfb_bank.sv
// rtl/dfb_bank.sv - simple dual-port bank RAM, one write port and one registered read port
module dfb_bank #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11,
  parameter int DW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/dual_frame_buffer.sv
// rtl/dual_frame_buffer.sv - double-buffered palette-indexed frame buffer with vblank swap and clear engine
module dual_frame_buffer import dfb_pkg::*; #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int CELL_LOG2 = 4,
  parameter int IDX_W     = 4,
  localparam int GRID_W   = H_RES >> CELL_LOG2,
  localparam int GRID_H   = V_RES >> CELL_LOG2,
  localparam int CX_W     = $clog2(GRID_W),
  localparam int CY_W     = $clog2(GRID_H)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             wr_en,
  input  logic [CX_W-1:0]  wr_cx,
  input  logic [CY_W-1:0]  wr_cy,
  input  logic [IDX_W-1:0] wr_idx,
  output logic             wr_ready,
  input  logic             clr_req,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             swap_req,
  output logic             swap_done,
  input  logic             pal_we,
  input  logic [IDX_W-1:0] pal_addr,
  input  logic [23:0]      pal_rgb,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW    = $clog2(CELLS);
  localparam int PAL_N = 2 ** IDX_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

  dfb_state_e       state_q;
  logic             front_sel_q, wr_ready_q, swap_done_q, swap_pend_q;
  logic             init_q, clr_bank_q;
  logic [AW-1:0]    clr_addr_q;
  logic [IDX_W-1:0] clr_val_q;

  logic             clearing, wr_ok, bank0_we, bank1_we, visible;
  logic [AW-1:0]    waddr, raddr;
  logic [IDX_W-1:0] wdata, rd0, rd1, idx_s1;
  logic             vis_s1_q, sel_s1_q;
  rgb_t             rgb_q;
  rgb_t             pal_q [PAL_N];

  assign clearing = (state_q == ST_CLEAR);
  assign wr_ok    = wr_en && wr_ready_q && (int'(wr_cx) < GRID_W) && (int'(wr_cy) < GRID_H);
  assign waddr    = clearing ? clr_addr_q : AW'(cell_addr(32'(wr_cx), 32'(wr_cy), GRID_W));
  assign wdata    = clearing ? clr_val_q : wr_idx;
  assign bank0_we = clearing ? !clr_bank_q : (wr_ok && front_sel_q);
  assign bank1_we = clearing ? clr_bank_q : (wr_ok && !front_sel_q);

  assign visible  = (int'(DrawX) < H_RES) && (int'(DrawY) < V_RES);
  assign raddr    = visible ? AW'(cell_addr(32'(DrawX >> CELL_LOG2), 32'(DrawY >> CELL_LOG2), GRID_W))
                            : '0;

  dfb_bank #(.DEPTH(CELLS), .AW(AW), .DW(IDX_W)) u_bank0 (
    .clk_i(Clk), .we_i(bank0_we), .waddr_i(waddr), .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rd0)
  );
  dfb_bank #(.DEPTH(CELLS), .AW(AW), .DW(IDX_W)) u_bank1 (
    .clk_i(Clk), .we_i(bank1_we), .waddr_i(waddr), .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rd1)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_CLEAR;
      front_sel_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      swap_done_q <= 1'b0;
      swap_pend_q <= 1'b0;
      init_q      <= 1'b1;
      clr_bank_q  <= 1'b1;
      clr_addr_q  <= '0;
      clr_val_q   <= '0;
    end else begin
      swap_done_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          if (swap_req) swap_pend_q <= 1'b1;
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_ADDR) begin
            clr_addr_q <= '0;
            // boot clears the back bank first, then the front bank
            if (init_q && clr_bank_q) begin
              clr_bank_q <= 1'b0;
            end else begin
              init_q <= 1'b0;
              if (swap_pend_q || swap_req) begin
                state_q     <= ST_WAIT_VB;
                swap_pend_q <= 1'b0;
              end else begin
                state_q    <= ST_IDLE;
                wr_ready_q <= 1'b1;
              end
            end
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            clr_val_q   <= clr_idx;
            clr_bank_q  <= ~front_sel_q;
            wr_ready_q  <= 1'b0;
            swap_pend_q <= swap_req;
          end else if (swap_req) begin
            state_q    <= ST_WAIT_VB;
            wr_ready_q <= 1'b0;
          end
        end
        ST_WAIT_VB: begin
          if (DrawY == 10'(V_RES) && DrawX == 10'd0) begin
            front_sel_q <= ~front_sel_q;
            swap_done_q <= 1'b1;
            state_q     <= ST_IDLE;
            wr_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign idx_s1 = sel_s1_q ? rd1 : rd0;

  // screen stays black until both banks hold defined data
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vis_s1_q <= 1'b0;
      sel_s1_q <= 1'b0;
      rgb_q    <= '0;
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= DEFAULT_PALETTE[i % 16];
    end else begin
      vis_s1_q <= visible && !init_q;
      sel_s1_q <= front_sel_q;
      rgb_q    <= vis_s1_q ? pal_q[idx_s1] : '0;
      if (pal_we) pal_q[pal_addr] <= pal_rgb;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign swap_done = swap_done_q;
  assign VGA_R     = rgb_q.r;
  assign VGA_G     = rgb_q.g;
  assign VGA_B     = rgb_q.b;

endmodule

// File: tb/tb_dual_frame_buffer.sv
// tb/tb_dual_frame_buffer.sv - directed self-checking bench for dual_frame_buffer
module tb_dual_frame_buffer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       wr_en;
  logic [5:0] wr_cx;
  logic [4:0] wr_cy;
  logic [3:0] wr_idx;
  logic       wr_ready;
  logic       clr_req;
  logic [3:0] clr_idx;
  logic       swap_req;
  logic       swap_done;
  logic       pal_we;
  logic [3:0] pal_addr;
  logic [23:0] pal_rgb;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic [23:0] vga;

  int compared   = 0;
  int mismatched = 0;

  dual_frame_buffer dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .wr_en(wr_en), .wr_cx(wr_cx), .wr_cy(wr_cy), .wr_idx(wr_idx), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_idx(clr_idx), .swap_req(swap_req), .swap_done(swap_done),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_rgb(pal_rgb),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;
  assign vga = {VGA_R, VGA_G, VGA_B};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick(2);
    check(tag, 32'(vga), 32'(exp));
  endtask

  // counts edges from reset release until wr_ready, watching VGA and swap_done meanwhile
  task automatic wait_ready(input string tag, input bit sweep);
    int  n;
    bit  vga_bad, sd_bad;
    n = 0; vga_bad = 0; sd_bad = 0;
    while (!wr_ready && n < 3000) begin
      if (sweep) begin
        DrawX = 10'(n % 800);
        DrawY = 10'(n % 525);
      end
      tick(1);
      n++;
      if (vga != 24'h0) vga_bad = 1'b1;
      if (swap_done) sd_bad = 1'b1;
    end
    check(tag, 32'(n), 32'd2400);
    check({tag, "_black"}, 32'(vga_bad), 32'd0);
    check({tag, "_no_swap"}, 32'(sd_bad), 32'd0);
  endtask

  task automatic request_swap();
    DrawX = 10'd0; DrawY = 10'd100;
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
  endtask

  task automatic vblank(input string tag);
    DrawX = 10'd0; DrawY = 10'd480;
    tick(1);
    check({tag, "_done"}, 32'(swap_done), 32'd1);
    DrawX = 10'd1;
    tick(1);
    check({tag, "_pulse"}, 32'(swap_done), 32'd0);
    check({tag, "_ready"}, 32'(wr_ready), 32'd1);
  endtask

  task automatic write_cell(input int cx, input int cy, input int idx);
    wr_cx = 6'(cx); wr_cy = 5'(cy); wr_idx = 4'(idx);
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  initial begin
    bit busy_bad;
    Reset = 1'b1; DrawX = 10'd100; DrawY = 10'd100;
    wr_en = 0; wr_cx = 0; wr_cy = 0; wr_idx = 0;
    clr_req = 0; clr_idx = 0; swap_req = 0;
    pal_we = 0; pal_addr = 0; pal_rgb = 0;
    tick(3);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    check("rst_vga", 32'(vga), 32'd0);

    Reset = 1'b0;
    wait_ready("boot", 1'b1);

    // palette[5] = orange, cell (3,2) = 5 in the back bank
    pal_addr = 4'd5; pal_rgb = 24'hFF8000; pal_we = 1'b1;
    tick(1);
    pal_we = 1'b0;
    write_cell(3, 2, 5);
    pix("front_untouched", 50, 40, 24'h000000);

    request_swap();
    check("wait_vb_ready", 32'(wr_ready), 32'd0);
    DrawX = 10'd0; DrawY = 10'd479;
    tick(3);
    check("no_swap_479", 32'(swap_done), 32'd0);
    DrawX = 10'd1; DrawY = 10'd480;
    tick(1);
    check("no_swap_x1", 32'(swap_done), 32'd0);
    vblank("swap1");

    pix("cell_tl", 48, 32, 24'hFF8000);
    pix("cell_br", 63, 47, 24'hFF8000);
    pix("cell_right", 64, 32, 24'h000000);
    pix("cell_left", 47, 40, 24'h000000);
    DrawX = 10'd55; DrawY = 10'd40;
    tick(1);
    check("latency_1", 32'(vga), 32'd0);
    tick(1);
    check("latency_2", 32'(vga), 32'hFF8000);

    // clear + swap together; writes during CLEAR and WAIT_VB must be dropped
    DrawX = 10'd0; DrawY = 10'd100;
    clr_idx = 4'd2; clr_req = 1'b1; swap_req = 1'b1;
    tick(1);
    clr_req = 1'b0; swap_req = 1'b0;
    busy_bad = 0;
    wr_en = 1'b1; wr_idx = 4'd7; wr_cy = 5'd0;
    for (int i = 0; i < 1300; i++) begin
      wr_cx = (i < 600) ? 6'd0 : 6'd1;
      tick(1);
      if (wr_ready || swap_done) busy_bad = 1'b1;
    end
    wr_en = 1'b0;
    check("clear_busy", 32'(busy_bad), 32'd0);
    vblank("swap2");
    pix("clr_0_0", 0, 0, 24'h0000FF);
    pix("clr_16_0", 16, 0, 24'h0000FF);
    pix("clr_639_479", 639, 479, 24'h0000FF);
    pix("clr_320_240", 320, 240, 24'h0000FF);

    // out-of-range cells into back bank (bank holding orange cell)
    write_cell(40, 0, 7);
    write_cell(45, 1, 7);
    write_cell(0, 30, 7);
    write_cell(3, 31, 7);
    request_swap();
    vblank("swap3");
    pix("oor_0_16", 0, 16, 24'h000000);
    pix("oor_80_32", 80, 32, 24'h000000);
    pix("oor_0_0", 0, 0, 24'h000000);
    pix("oor_keep", 48, 32, 24'hFF8000);

    // fill with red index 7, then blanking and palette timing
    DrawX = 10'd0; DrawY = 10'd100;
    clr_idx = 4'd7; clr_req = 1'b1; swap_req = 1'b1;
    tick(1);
    clr_req = 1'b0; swap_req = 1'b0;
    tick(1300);
    vblank("swap4");
    pix("blank_x700", 700, 200, 24'h000000);
    pix("red_100_200", 100, 200, 24'hFF0000);
    pix("blank_y480", 100, 480, 24'h000000);
    pix("red_again", 100, 200, 24'hFF0000);
    pal_addr = 4'd7; pal_rgb = 24'h123456; pal_we = 1'b1;
    tick(1);
    pal_we = 1'b0;
    check("pal_old", 32'(vga), 32'hFF0000);
    tick(1);
    check("pal_new", 32'(vga), 32'h123456);

    // reset in the middle of a pending swap with bank 1 in front
    request_swap();
    vblank("swap5");
    check("front_is_1", 32'(dut.front_sel_q), 32'd1);
    request_swap();
    check("wait_vb_again", 32'(wr_ready), 32'd0);
    #2 Reset = 1'b1;
    #1 check("async_rst_ready", 32'(wr_ready), 32'd0);
    DrawX = 10'd0; DrawY = 10'd480;
    tick(2);
    check("rst_front_sel", 32'(dut.front_sel_q), 32'd0);
    check("rst_no_swap", 32'(swap_done), 32'd0);
    check("rst_vga_black", 32'(vga), 32'd0);
    Reset = 1'b0;
    wait_ready("reboot", 1'b0);
    pix("reboot_black", 100, 200, 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dual_frame_buffer.md
# dual_frame_buffer

Double-buffered, palette-indexed frame buffer sitting between the game logic (Tetris board and sprite renderer) and the VGA output stage. Game logic draws into a back bank through a cell-addressed write port while the front bank is scanned out using the VGA controller's DrawX/DrawY. Bank swaps are deferred to the start of vertical blank so that frames never tear. A clear engine fills the back bank with a chosen colour index. A programmable palette expands indices to 24-bit RGB.

## Interface
- H_RES, 640: visible width in pixels
- V_RES, 480: visible height in pixels
- CELL_LOG2, 4: log2 of cell edge in pixels; grid is (H_RES>>CELL_LOG2) x (V_RES>>CELL_LOG2), 40x30 by default
- IDX_W, 4: colour index width; palette has 2**IDX_W entries

- Clk  in  1  system clock (pixel clock domain)
- Reset  in  1  asynchronous, active-high reset
- DrawX, DrawY  in  10 each  current scan pixel from the VGA controller
- wr_en  in  1  write one cell of the back bank
- wr_cx, wr_cy  in  $clog2(grid W), $clog2(grid H)  cell coordinates
- wr_idx  in  IDX_W  colour index to write
- wr_ready  out  1  high when writes are accepted
- clr_req  in  1  pulse: fill the back bank with clr_idx
- clr_idx  in  IDX_W  fill colour index, sampled when clr_req is accepted
- swap_req  in  1  pulse: request a front/back exchange
- swap_done  out  1  one-cycle pulse when the swap takes effect
- pal_we, pal_addr (IDX_W), pal_rgb (24)  in  palette write port
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour

## Operation
- Banks: two RAMs of W*H entries, IDX_W bits each. Address = cy*W + cx. front_sel selects the scanned bank; the back bank is !front_sel.
- FSM states:
  - CLEAR: writes the latched clear index to back-bank addresses 0..W*H-1, one per cycle. On the last address, goes to IDLE, or to WAIT_VB if a swap is pending.
  - IDLE: wr_ready=1. A wr_en write completes in the same cycle.
    - clr_req has priority over swap_req and enters CLEAR with address 0.
    - swap_req enters WAIT_VB.
  - WAIT_VB: wr_ready=0. When DrawY==V_RES and DrawX==0, front_sel toggles, swap_done pulses for 1 cycle, and the FSM goes to IDLE.
- swap_req arriving during CLEAR is latched and served after the clear completes. A second swap_req while one is pending is ignored. clr_req outside IDLE is ignored.
- wr_en with wr_ready=0 is dropped. Out-of-range cell coordinates (cx>=W or cy>=H) are dropped.
- Readout: cell = (DrawX>>CELL_LOG2, DrawY>>CELL_LOG2) from the front bank, then palette lookup. Pixels with DrawX>=H_RES or DrawY>=V_RES output 0,0,0.
- Palette:
  - Reset contents are DEFAULT_PALETTE from the package; entry 0 is black.
  - pal_we updates the entry at the next edge.
  - A lookup in the same cycle as a write to that entry returns the old value.

## Timing
- Reset (asynchronous):
  - front_sel=0, wr_ready=0, swap_done=0, VGA_R/G/B=0, palette set to defaults.
  - The FSM enters CLEAR with index 0, then clears the other bank as well. That is 2*W*H cycles (2400 by default), after which it is IDLE with wr_ready=1.
  - Reset asserted mid-clear or mid-swap aborts the operation and restarts this sequence.
- Readout latency is exactly 2 Clk cycles from DrawX/DrawY to VGA_*:
  - stage 1 registers the bank read and a visible flag;
  - stage 2 registers the palette output.
  - The VGA controller compensates for this latency in its sync timing.
- A write in IDLE is visible on screen only after the next completed swap, never in the current front frame.
- swap_done is asserted in the cycle after the edge that samples DrawY==V_RES, DrawX==0. The first visible pixel of the next frame comes from the new bank.
- clr_req and swap_req in the same IDLE cycle: the clear runs first, then the swap waits for vblank.

## Structure
- Package dfb_pkg holds:
  - the FSM state enum (CLEAR, IDLE, WAIT_VB);
  - typedef rgb_t (24-bit packed r/g/b);
  - DEFAULT_PALETTE (16 x rgb_t: black, the seven tetromino colours, greys, white);
  - helper function cell_addr(cx, cy).
- Sub-module dfb_bank: single-clock simple dual-port RAM with one write port and one registered read port, no reset. It is instantiated twice, with write-enable steering by !front_sel.

## Test plan
- Reset released, DrawX/DrawY swept: wr_ready rises exactly 2400 cycles after release, and VGA_* stays 0 at every pixel.
- Write cx=3, cy=2, idx=5 with palette[5]=0xFF8000, then swap_req at DrawY=100: swap_done fires at DrawY=480, DrawX=0. Next frame, pixels (48..63, 32..47) show R=FF, G=80, B=00, arriving 2 cycles after DrawX/DrawY.
- clr_req and swap_req in the same cycle with clr_idx=2:
  - wr_ready stays low for 1200 cycles and then through WAIT_VB;
  - after swap_done the whole visible frame shows palette[2].
- Writes with wr_ready=0 during CLEAR or WAIT_VB, and writes to cx=40 or cy=30: no change in the following displayed frame.
- DrawX=700, DrawY=200 on a bank filled with idx=7: output 0,0,0. Palette write to entry 7 during scanout: the new colour appears from the 2nd cycle after the write.
- Reset asserted mid-WAIT_VB: front_sel returns to 0, no swap_done, and the 2400-cycle clear reruns.
